dcache_refill_buffer: RTL and testbench

Collects the read-data beats of one data-cache line refill from `mem_read` (the source-2 beats, `valid2`) and assembles them into a full line for the D-cache data RAM. AXI reads are WRAP bursts, so beats arrive critical word first and wrap inside the line. The block forwards the critical word for early restart and lets the load pipeline probe words that have already arrived. It presents the completed line to the cache write port with a valid/ready handshake.

---
 rtl/dcache_refill_buffer_pkg.sv | 13 +
 rtl/dcache_refill_buffer.sv | 166 ++++++++++++++++
 tb/tb_dcache_refill_buffer.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_refill_buffer_pkg.sv
// Shared types and sizing helpers for the D-cache refill buffer.
package dcache_refill_buffer_pkg;

    typedef enum logic [1:0] {RF_IDLE, RF_FILL, RF_DRAIN, RF_HOLD} refill_state_e;

    localparam int unsigned DEFAULT_LINE_BYTE_OFFSET = 6;
    localparam int unsigned WORD_IDX_W = DEFAULT_LINE_BYTE_OFFSET - 2;

    function automatic int unsigned word_idx_width(input int unsigned line_byte_offset);
        return line_byte_offset - 2;
    endfunction

endpackage

// File: rtl/dcache_refill_buffer.sv
// Assembles one WRAP-burst cache-line refill, forwards the critical word,
// serves probes of arrived words and offers the full line to the data RAM.
module dcache_refill_buffer
    import dcache_refill_buffer_pkg::*;
#(
    parameter int unsigned LINE_BYTE_OFFSET = DEFAULT_LINE_BYTE_OFFSET
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_flush,
    input  logic                             i_beat_valid,
    input  logic [31:0]                      i_beat_data,
    input  logic                             i_beat_last,
    input  logic [31:0]                      i_first_addr,
    output logic                             o_busy,
    output logic                             o_crit_valid,
    output logic [31:0]                      o_crit_data,
    input  logic [31:0]                      i_probe_addr,
    output logic                             o_probe_hit,
    output logic [31:0]                      o_probe_data,
    output logic                             o_line_valid,
    output logic [32-LINE_BYTE_OFFSET-1:0]   o_line_addr,
    output logic [32*(2**(LINE_BYTE_OFFSET-2))-1:0] o_line_data,
    input  logic                             i_line_ready,
    output logic                             o_err
);

    localparam int unsigned IDX_W      = word_idx_width(LINE_BYTE_OFFSET);
    localparam int unsigned LINE_WORDS = 1 << IDX_W;
    localparam int unsigned TAG_W      = 32 - LINE_BYTE_OFFSET;
    localparam int unsigned CNT_W      = IDX_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LINE_WORDS - 1);

    refill_state_e          state;
    logic [TAG_W-1:0]       line_addr;
    logic [IDX_W-1:0]       start_idx;
    logic [CNT_W-1:0]       count;
    logic [LINE_WORDS-1:0]  mask;
    logic [31:0]            store [LINE_WORDS];
    logic                   crit_valid;
    logic [31:0]            crit_data;
    logic                   err;

    logic [IDX_W-1:0]       first_idx;
    logic [IDX_W-1:0]       fill_idx;
    logic [IDX_W-1:0]       probe_idx;
    logic                   start_fill;
    logic                   fill_write;
    logic                   unused_addr_bits;

    assign first_idx = i_first_addr[LINE_BYTE_OFFSET-1:2];
    assign probe_idx = i_probe_addr[LINE_BYTE_OFFSET-1:2];
    // Index wraps inside the line, matching the AXI WRAP burst order.
    assign fill_idx  = start_idx + count[IDX_W-1:0];
    assign unused_addr_bits = ^{i_first_addr[1:0], i_probe_addr[1:0]};

    // A first beat is accepted in IDLE, or in HOLD when the old line leaves the same cycle.
    assign start_fill = i_beat_valid &&
                        (state == RF_IDLE || (state == RF_HOLD && i_line_ready && !i_flush));
    assign fill_write = state == RF_FILL && i_beat_valid && !i_flush &&
                        (count != LAST_CNT || i_beat_last);

    always_ff @(posedge i_clk) begin
        if (start_fill) begin
            store[first_idx] <= i_beat_data;
        end else if (fill_write) begin
            store[fill_idx] <= i_beat_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= RF_IDLE;
            line_addr  <= '0;
            start_idx  <= '0;
            count      <= '0;
            mask       <= '0;
            crit_valid <= 1'b0;
            crit_data  <= '0;
            err        <= 1'b0;
        end else begin
            crit_valid <= 1'b0;
            err        <= 1'b0;
            if (start_fill) begin
                line_addr  <= i_first_addr[31:LINE_BYTE_OFFSET];
                start_idx  <= first_idx;
                count      <= CNT_W'(1);
                crit_valid <= 1'b1;
                crit_data  <= i_beat_data;
                if (i_beat_last) begin
                    err   <= 1'b1;
                    state <= RF_IDLE;
                    mask  <= '0;
                end else begin
                    state <= RF_FILL;
                    mask  <= LINE_WORDS'(1) << first_idx;
                end
            end else begin
                unique case (state)
                    RF_IDLE: begin
                    end
                    RF_FILL: begin
                        if (i_flush) begin
                            if (i_beat_valid && i_beat_last) begin
                                state <= RF_IDLE;
                                mask  <= '0;
                            end else begin
                                state <= RF_DRAIN;
                            end
                        end else if (i_beat_valid) begin
                            if (count == LAST_CNT && i_beat_last) begin
                                mask  <= mask | (LINE_WORDS'(1) << fill_idx);
                                count <= count + CNT_W'(1);
                                state <= RF_HOLD;
                            end else if (count == LAST_CNT) begin
                                err   <= 1'b1;
                                state <= RF_DRAIN;
                            end else if (i_beat_last) begin
                                err   <= 1'b1;
                                state <= RF_IDLE;
                                mask  <= '0;
                            end else begin
                                mask  <= mask | (LINE_WORDS'(1) << fill_idx);
                                count <= count + CNT_W'(1);
                            end
                        end
                    end
                    RF_DRAIN: begin
                        if (i_beat_valid && i_beat_last) begin
                            state <= RF_IDLE;
                            mask  <= '0;
                        end
                    end
                    RF_HOLD: begin
                        if (i_flush || i_line_ready) begin
                            state <= RF_IDLE;
                            mask  <= '0;
                        end else if (i_beat_valid) begin
                            err <= 1'b1;
                        end
                    end
                    default: state <= RF_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        o_busy       = state != RF_IDLE;
        o_crit_valid = crit_valid;
        o_crit_data  = crit_data;
        o_err        = err;
        o_line_valid = state == RF_HOLD;
        o_line_addr  = (state == RF_HOLD) ? line_addr : '0;
        o_line_data  = '0;
        for (int w = 0; w < LINE_WORDS; w++) begin
            if (state == RF_HOLD) begin
                o_line_data[32*w +: 32] = store[w];
            end
        end
        o_probe_hit  = (state == RF_FILL || state == RF_HOLD) &&
                       i_probe_addr[31:LINE_BYTE_OFFSET] == line_addr && mask[probe_idx];
        o_probe_data = o_probe_hit ? store[probe_idx] : '0;
    end

endmodule

// File: tb/tb_dcache_refill_buffer.sv
// Randomized bench for dcache_refill_buffer against a word-level line model.
module tb_dcache_refill_buffer;

    localparam int LW = 16;

    logic         clk;
    logic         rst;
    logic         flush;
    logic         beat_valid;
    logic [31:0]  beat_data;
    logic         beat_last;
    logic [31:0]  first_addr;
    logic         busy;
    logic         crit_valid;
    logic [31:0]  crit_data;
    logic [31:0]  probe_addr;
    logic         probe_hit;
    logic [31:0]  probe_data;
    logic         line_valid;
    logic [25:0]  line_addr;
    logic [511:0] line_data;
    logic         line_ready;
    logic         err;

    int checks = 0;
    int failures = 0;

    // Model: line tag, start word, word contents and arrival flags.
    logic [25:0] m_tag;
    int          m_start;
    logic [31:0] m_words [LW];
    bit          m_present [LW];

    dcache_refill_buffer #(.LINE_BYTE_OFFSET(6)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_flush      (flush),
        .i_beat_valid (beat_valid),
        .i_beat_data  (beat_data),
        .i_beat_last  (beat_last),
        .i_first_addr (first_addr),
        .o_busy       (busy),
        .o_crit_valid (crit_valid),
        .o_crit_data  (crit_data),
        .i_probe_addr (probe_addr),
        .o_probe_hit  (probe_hit),
        .o_probe_data (probe_data),
        .o_line_valid (line_valid),
        .o_line_addr  (line_addr),
        .o_line_data  (line_data),
        .i_line_ready (line_ready),
        .o_err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] model_line();
        logic [511:0] v;
        for (int w = 0; w < LW; w++) v[32*w +: 32] = m_words[w];
        return v;
    endfunction

    // Drives n consecutive beats of a burst starting at addr and checks every cycle.
    task automatic drive_burst(input logic [31:0] addr, input int n, input bit mark_last,
                               input bit seq_data, input bit fixed_probe,
                               input logic [31:0] probe_fixed, input string name);
        logic [31:0] d;
        bit short_end, complete;
        int w;
        logic [3:0] pidx;
        bit exp_hit;
        logic [31:0] exp_data;
        m_tag = addr[31:6];
        m_start = int'(addr[5:2]);
        for (int i = 0; i < LW; i++) m_present[i] = 1'b0;
        for (int k = 0; k < n; k++) begin
            d = seq_data ? 32'hA0 + k : $urandom;
            beat_valid = 1'b1;
            beat_data = d;
            beat_last = mark_last && (k == n - 1);
            first_addr = (k == 0) ? addr : $urandom;
            if (fixed_probe) probe_addr = probe_fixed;
            else if ($urandom_range(0, 3) == 0) probe_addr = $urandom;
            else probe_addr = {m_tag, 4'($urandom), 2'($urandom)};
            step();
            line_ready = 1'b0;
            short_end = mark_last && (k == n - 1) && (n != LW);
            complete = mark_last && (k == n - 1) && (n == LW);
            w = (m_start + k) % LW;
            m_words[w] = d;
            m_present[w] = 1'b1;

            checks++;
            if (crit_valid !== (k == 0) || (k == 0 && crit_data !== d)) begin
                failures++;
                $display("FAIL %s crit beat %0d: got valid=%0b data=%h, expected valid=%0b data=%h",
                         name, k, crit_valid, crit_data, k == 0, d);
            end
            checks++;
            if (err !== short_end || busy !== !short_end || line_valid !== complete) begin
                failures++;
                $display("FAIL %s status beat %0d: got err=%0b busy=%0b lv=%0b, expected %0b %0b %0b",
                         name, k, err, busy, line_valid, short_end, !short_end, complete);
            end
            pidx = probe_addr[5:2];
            exp_hit = !short_end && probe_addr[31:6] == m_tag && m_present[pidx];
            exp_data = exp_hit ? m_words[pidx] : 32'h0;
            checks++;
            if (probe_hit !== exp_hit || probe_data !== exp_data) begin
                failures++;
                $display("FAIL %s probe beat %0d addr %h: got hit=%0b data=%h, expected %0b %h",
                         name, k, probe_addr, probe_hit, probe_data, exp_hit, exp_data);
            end
        end
        beat_valid = 1'b0;
        beat_last = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush = 1'b0;
        beat_valid = 1'b0;
        beat_data = '0;
        beat_last = 1'b0;
        first_addr = '0;
        probe_addr = '0;
        line_ready = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || crit_valid !== 1'b0 || crit_data !== 32'h0 || err !== 1'b0 ||
            line_valid !== 1'b0 || line_addr !== 26'h0 || line_data !== 512'h0 ||
            probe_hit !== 1'b0 || probe_data !== 32'h0) begin
            failures++;
            $display("FAIL reset: got busy=%0b cv=%0b cd=%h err=%0b lv=%0b la=%h hit=%0b pd=%h, expected all 0",
                     busy, crit_valid, crit_data, err, line_valid, line_addr, probe_hit, probe_data);
        end
    endtask

    task automatic test_aligned_fill();
        drive_burst(32'h1000_0000, LW, 1'b1, 1'b1, 1'b0, 32'h0, "aligned");
        checks++;
        if (line_valid !== 1'b1 || line_addr !== 26'h40_0000) begin
            failures++;
            $display("FAIL aligned line addr: got lv=%0b addr=%h, expected 1 400000", line_valid, line_addr);
        end
        for (int i = 0; i < LW; i++) begin
            checks++;
            if (line_data[32*i +: 32] !== 32'hA0 + i) begin
                failures++;
                $display("FAIL aligned word %0d: got %h, expected %h", i, line_data[32*i +: 32], 32'hA0 + i);
            end
        end
        line_ready = 1'b1;
        step();
        line_ready = 1'b0;
        checks++;
        if (line_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL aligned handoff: got lv=%0b busy=%0b, expected 0 0", line_valid, busy);
        end
    endtask

    task automatic test_wrapped_fill();
        // Probe word 0 throughout: it is the fourth beat when starting at word 13.
        drive_burst(32'h1000_0034, LW, 1'b1, 1'b0, 1'b1, 32'h1000_0000, "wrapped");
        checks++;
        if (line_valid !== 1'b1 || line_addr !== m_tag || line_data !== model_line()) begin
            failures++;
            $display("FAIL wrapped line: got lv=%0b addr=%h data=%h, expected addr=%h data=%h",
                     line_valid, line_addr, line_data, m_tag, model_line());
        end
        line_ready = 1'b1;
        step();
        line_ready = 1'b0;
        checks++;
        if (line_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL wrapped handoff: got lv=%0b busy=%0b, expected 0 0", line_valid, busy);
        end
    endtask

    task automatic test_backpressure();
        logic [511:0] exp_line;
        drive_burst($urandom, LW, 1'b1, 1'b0, 1'b0, 32'h0, "bp_fill");
        exp_line = model_line();
        for (int c = 0; c < 5; c++) begin
            line_ready = 1'b0;
            beat_valid = (c == 1);
            beat_data = $urandom;
            first_addr = $urandom;
            step();
            beat_valid = 1'b0;
            checks++;
            if (line_valid !== 1'b1 || line_data !== exp_line || line_addr !== m_tag ||
                busy !== 1'b1 || err !== (c == 1)) begin
                failures++;
                $display("FAIL backpressure cycle %0d: got lv=%0b busy=%0b err=%0b addr=%h, expected 1 1 %0b %h",
                         c, line_valid, busy, err, line_addr, c == 1, m_tag);
            end
        end
        line_ready = 1'b1;
        step();
        line_ready = 1'b0;
        checks++;
        if (line_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL backpressure handoff: got lv=%0b busy=%0b err=%0b, expected 0 0 0",
                     line_valid, busy, err);
        end
    endtask

    task automatic test_flush();
        logic [31:0] addr;
        addr = $urandom;
        drive_burst(addr, 6, 1'b0, 1'b0, 1'b0, 32'h0, "flush_fill");
        flush = 1'b1;
        probe_addr = addr;
        step();
        flush = 1'b0;
        checks++;
        if (busy !== 1'b1 || line_valid !== 1'b0 || err !== 1'b0 || probe_hit !== 1'b0) begin
            failures++;
            $display("FAIL flush entry: got busy=%0b lv=%0b err=%0b hit=%0b, expected 1 0 0 0",
                     busy, line_valid, err, probe_hit);
        end
        for (int k = 0; k < 10; k++) begin
            beat_valid = 1'b1;
            beat_data = $urandom;
            beat_last = (k == 9);
            step();
            checks++;
            if (line_valid !== 1'b0 || err !== 1'b0 || probe_hit !== 1'b0 || busy !== (k < 9)) begin
                failures++;
                $display("FAIL flush drain beat %0d: got lv=%0b err=%0b hit=%0b busy=%0b, expected 0 0 0 %0b",
                         k, line_valid, err, probe_hit, busy, k < 9);
            end
        end
        beat_valid = 1'b0;
        beat_last = 1'b0;
        // Flush coinciding with the last beat returns straight to idle.
        drive_burst($urandom, 3, 1'b0, 1'b0, 1'b0, 32'h0, "flush_last_fill");
        flush = 1'b1;
        beat_valid = 1'b1;
        beat_last = 1'b1;
        step();
        flush = 1'b0;
        beat_valid = 1'b0;
        beat_last = 1'b0;
        checks++;
        if (busy !== 1'b0 || err !== 1'b0 || line_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush with last: got busy=%0b err=%0b lv=%0b, expected 0 0 0",
                     busy, err, line_valid);
        end
    endtask

    task automatic test_short_burst();
        logic [31:0] addr;
        addr = $urandom;
        drive_burst(addr, 9, 1'b1, 1'b0, 1'b1, addr, "short");
        step();
        checks++;
        if (err !== 1'b0 || busy !== 1'b0 || probe_hit !== 1'b0 || line_valid !== 1'b0) begin
            failures++;
            $display("FAIL short after: got err=%0b busy=%0b hit=%0b lv=%0b, expected 0 0 0 0",
                     err, busy, probe_hit, line_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addr_a;
        logic [31:0] addr_b;
        logic [25:0] tag_a;
        logic [511:0] line_a;
        addr_a = $urandom;
        tag_a = addr_a[31:6];
        drive_burst(addr_a, LW, 1'b1, 1'b0, 1'b0, 32'h0, "b2b_a");
        line_a = model_line();
        line_ready = 1'b1;
        checks++;
        if (line_valid !== 1'b1 || line_addr !== tag_a || line_data !== line_a) begin
            failures++;
            $display("FAIL b2b old line: got lv=%0b addr=%h, expected 1 %h", line_valid, line_addr, tag_a);
        end
        addr_b = {tag_a ^ 26'h1, 4'($urandom), 2'b00};
        // Probing the old tag at the new start word must miss for the whole new fill.
        drive_burst(addr_b, LW, 1'b1, 1'b0, 1'b1, {tag_a, addr_b[5:0]}, "b2b_b");
        probe_addr = addr_b;
        #1;
        checks++;
        if (probe_hit !== 1'b1 || probe_data !== m_words[addr_b[5:2]]) begin
            failures++;
            $display("FAIL b2b new probe: got hit=%0b data=%h, expected 1 %h",
                     probe_hit, probe_data, m_words[addr_b[5:2]]);
        end
        checks++;
        if (line_valid !== 1'b1 || line_addr !== m_tag || line_data !== model_line()) begin
            failures++;
            $display("FAIL b2b new line: got lv=%0b addr=%h, expected 1 %h", line_valid, line_addr, m_tag);
        end
        line_ready = 1'b1;
        step();
        line_ready = 1'b0;
    endtask

    task automatic test_random_fills();
        logic [511:0] exp_line;
        int waits;
        for (int it = 0; it < 4; it++) begin
            drive_burst($urandom, LW, 1'b1, 1'b0, 1'b0, 32'h0, "rand_fill");
            exp_line = model_line();
            waits = $urandom_range(0, 3);
            for (int c = 0; c <= waits; c++) begin
                line_ready = (c == waits);
                checks++;
                if (line_valid !== 1'b1 || line_data !== exp_line || line_addr !== m_tag) begin
                    failures++;
                    $display("FAIL rand line it %0d cycle %0d: got lv=%0b addr=%h, expected 1 %h",
                             it, c, line_valid, line_addr, m_tag);
                end
                step();
            end
            line_ready = 1'b0;
            checks++;
            if (line_valid !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL rand handoff it %0d: got lv=%0b busy=%0b, expected 0 0",
                         it, line_valid, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_aligned_fill();
        test_wrapped_fill();
        test_backpressure();
        test_flush();
        test_short_burst();
        test_back_to_back();
        test_random_fills();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
